// File: rtl/queue_manager_mc.sv
// queue_manager_mc -- per-channel FIFOs of timed operations (WAIT n / PULSE / NOP)
// that drive the pulse-trigger outputs of the q-pipeline. Each channel owns a FIFO
// and an executor (IDLE/WAIT). The channels drain independently of each other.
//
// Ports
//   clk, rst  clock (posedge) and asynchronous active-high reset
//   in_valid  push request
//   in_ch     target channel
//   in_op     00 WAIT, 01 PULSE, 1x NOP
//   in_arg    wait count or pulse code
//   in_ready  target channel not full (combinational)
//   flush     per-channel synchronous clear
//   trg       per channel {fire, arg}, registered
//   busy      per channel: FIFO non-empty or executor counting a WAIT, registered
//   run       pop enable for IDLE executors (only with QM_RUN_GATE_EN)
//
// Configuration macro: QM_RUN_GATE_EN adds the run input.
module queue_manager_mc #(
  parameter int NCH   = 4,
  parameter int DEPTH = 8,
  parameter int IW    = 7,
  localparam int CW   = (NCH > 1) ? $clog2(NCH) : 1,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [CW-1:0]         in_ch,
  input  logic [1:0]            in_op,
  input  logic [IW-1:0]         in_arg,
  input  logic [NCH-1:0]        flush,
  output logic [NCH*(IW+1)-1:0] trg,
`ifdef QM_RUN_GATE_EN
  output logic [NCH-1:0]        busy,
  input  logic                  run
`else
  output logic [NCH-1:0]        busy
`endif
);

  typedef enum logic {ST_IDLE, ST_WAIT} st_t;

  logic run_ok;
`ifdef QM_RUN_GATE_EN
  assign run_ok = run;
`else
  assign run_ok = 1'b1;
`endif

  logic [NCH-1:0] rdy_c;
  // Out-of-range channel numbers select no lane, so in_ready stays low.
  assign in_ready = |rdy_c;

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    logic [DEPTH-1:0][IW+1:0] mem_q;
    logic [AW:0]              occ_q, occ_d;
    logic [AW-1:0]            wp_q, rp_q;
    st_t                      st_q;
    logic [IW-1:0]            wcnt_q;
    logic                     fire_q, busy_q;
    logic [IW-1:0]            arg_q;
    logic                     sel, full, push, pop, go_wait;
    logic [1:0]               hop;
    logic [IW-1:0]            harg;

    assign sel      = (in_ch == CW'(c));
    assign full     = (occ_q == (AW+1)'(DEPTH));
    assign rdy_c[c] = sel & ~full;
    // in_ready is not masked by flush; the flush simply drops the entry.
    assign push     = in_valid & sel & ~full & ~flush[c];
    assign pop      = (st_q == ST_IDLE) & (occ_q != '0) & run_ok & ~flush[c];
    assign {hop, harg} = mem_q[rp_q];

    always_comb begin
      occ_d = occ_q;
      if (flush[c])           occ_d = '0;
      else if (push && !pop)  occ_d = occ_q + 1'b1;
      else if (pop && !push)  occ_d = occ_q - 1'b1;
    end

    // Executor will be in WAIT after this edge: either still counting or
    // starting a WAIT of n>=2 now.
    assign go_wait = ~flush[c] &
                     (((st_q == ST_WAIT) & (wcnt_q != IW'(1))) |
                      (pop & (hop == 2'b00) & (harg >= IW'(2))));

    always_ff @(posedge clk) begin
      if (push) mem_q[wp_q] <= {in_op, in_arg};
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        occ_q  <= '0;
        wp_q   <= '0;
        rp_q   <= '0;
        st_q   <= ST_IDLE;
        wcnt_q <= '0;
        fire_q <= 1'b0;
        arg_q  <= '0;
        busy_q <= 1'b0;
      end else begin
        occ_q  <= occ_d;
        busy_q <= (occ_d != '0) | go_wait;
        fire_q <= 1'b0;
        if (flush[c]) begin
          wp_q   <= '0;
          rp_q   <= '0;
          st_q   <= ST_IDLE;
          wcnt_q <= '0;
        end else begin
          if (push) wp_q <= wp_q + 1'b1;
          if (pop)  rp_q <= rp_q + 1'b1;
          if (st_q == ST_WAIT) begin
            wcnt_q <= wcnt_q - 1'b1;
            if (wcnt_q == IW'(1)) st_q <= ST_IDLE;
          end else if (pop) begin
            if (hop == 2'b01) begin
              fire_q <= 1'b1;
              arg_q  <= harg;
            end else if (hop == 2'b00 && harg >= IW'(2)) begin
              // WAIT n blocks the next pop until P+n.
              wcnt_q <= harg - 1'b1;
              st_q   <= ST_WAIT;
            end
          end
        end
      end
    end

    assign trg[c*(IW+1) +: IW+1] = {fire_q, arg_q};
    assign busy[c]               = busy_q;
  end

endmodule

// File: tb/tb_queue_manager_mc.sv
// Bench for queue_manager_mc: directed scenarios followed by random traffic,
// checked every cycle against a queue-based model that tracks, per channel,
// the earliest cycle at which the next pop may happen.
module tb_queue_manager_mc;
  localparam int NCH = 4, DEPTH = 8, IW = 7;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  in_valid;
  logic                  in_ready;
  logic [1:0]            in_ch;
  logic [1:0]            in_op;
  logic [IW-1:0]         in_arg;
  logic [NCH-1:0]        flush;
  logic [NCH*(IW+1)-1:0] trg;
  logic [NCH-1:0]        busy;
  logic                  run_v = 1'b1;
`ifdef QM_RUN_GATE_EN
  logic                  run;
`endif

  always #5 clk = ~clk;

  queue_manager_mc #(.NCH(NCH), .DEPTH(DEPTH), .IW(IW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_ch(in_ch), .in_op(in_op), .in_arg(in_arg), .flush(flush),
`ifdef QM_RUN_GATE_EN
    .run(run),
`endif
    .trg(trg), .busy(busy)
  );

  // Reference model
  logic [8:0]     mq[NCH][$];
  int             nxt[NCH];
  logic           fire_m[NCH];
  logic [IW-1:0]  arg_m[NCH];
  logic [NCH-1:0] busy_m;
  int             cyc;
  int             errors = 0;
  int             checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_trg();
    logic [31:0] v;
    v = '0;
    for (int c = 0; c < NCH; c++) v[c*8 +: 8] = {fire_m[c], arg_m[c]};
    return v;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      mq[c].delete();
      nxt[c] = 0;
      fire_m[c] = 1'b0;
      arg_m[c] = '0;
    end
    busy_m = '0;
  endtask

  task automatic model_edge(input logic acc, input int ch, input logic [8:0] ent,
                            input logic [NCH-1:0] fl);
    logic [8:0] e;
    for (int c = 0; c < NCH; c++) begin
      fire_m[c] = 1'b0;
      if (fl[c]) begin
        mq[c].delete();
        nxt[c] = cyc + 1;
      end else begin
        if (run_v && mq[c].size() > 0 && cyc >= nxt[c]) begin
          e = mq[c].pop_front();
          nxt[c] = cyc + 1;
          if (e[8:7] == 2'b01) begin
            fire_m[c] = 1'b1;
            arg_m[c]  = e[6:0];
          end else if (e[8:7] == 2'b00 && int'(e[6:0]) >= 2) begin
            nxt[c] = cyc + int'(e[6:0]);
          end
        end
        if (acc && ch == c) mq[c].push_back(ent);
      end
      busy_m[c] = (mq[c].size() > 0) || (nxt[c] > cyc + 1);
    end
  endtask

  // One clock cycle: called at posedge+1, returns at the next posedge+1.
  task automatic step(input logic v, input logic [1:0] ch, input logic [1:0] op,
                      input logic [IW-1:0] a, input logic [NCH-1:0] fl);
    logic er;
    in_valid = v; in_ch = ch; in_op = op; in_arg = a; flush = fl;
`ifdef QM_RUN_GATE_EN
    run = run_v;
`endif
    #4;
    er = mq[ch].size() < DEPTH;
    chk("in_ready", in_ready, er);
    @(posedge clk);
    model_edge(v & er, int'(ch), {op, a}, fl);
    cyc++;
    #1;
    chk("trg", trg, exp_trg());
    chk("busy", busy, busy_m);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 2'd0, 2'd0, '0, '0);
  endtask

  initial begin
    cyc = 0;
    model_reset();
    rst = 1'b1; in_valid = 1'b0; in_ch = '0; in_op = '0; in_arg = '0; flush = '0;
`ifdef QM_RUN_GATE_EN
    run = 1'b1;
`endif
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    // 1: reset state
    chk("rst_trg", trg, 32'h0);
    chk("rst_busy", busy, 32'h0);
    for (int c = 0; c < NCH; c++) begin
      in_ch = 2'(c);
      #1 chk("rst_ready", in_ready, 32'h1);
    end
    @(posedge clk); #1;

    // 2: single pulse on ch0
    step(1'b1, 2'd0, 2'b01, 7'h15, '0);
    idle(1);
    chk("t2_fire", trg[7:0], 32'h95);
    idle(1);
    chk("t2_hold", trg[7:0], 32'h15);

    // 3: PULSE 3, WAIT 5, PULSE 4 on ch1
    step(1'b1, 2'd1, 2'b01, 7'd3, '0);
    step(1'b1, 2'd1, 2'b00, 7'd5, '0);
    step(1'b1, 2'd1, 2'b01, 7'd4, '0);
    idle(8);

    // 4: fill ch2 behind a WAIT 100, refuse the 9th, flush, refill
    step(1'b1, 2'd2, 2'b00, 7'd100, '0);
    for (int i = 0; i < DEPTH; i++) step(1'b1, 2'd2, 2'b01, 7'(i + 1), '0);
    in_valid = 1'b1; in_ch = 2'd2;
    #1 chk("t4_full", in_ready, 32'h0);
    step(1'b1, 2'd2, 2'b01, 7'h7f, '0);
    step(1'b0, 2'd0, 2'b00, '0, 4'b0100);
    chk("t4_busy", busy[2], 32'h0);
    for (int i = 0; i < DEPTH; i++) step(1'b1, 2'd2, 2'b01, 7'(i + 16), '0);
    idle(10);

    // 5: flush vs same-cycle push and pending pop on ch3
    step(1'b1, 2'd3, 2'b01, 7'h22, '0);
    step(1'b1, 2'd3, 2'b01, 7'h33, 4'b1000);
    chk("t5_fire", trg[31], 32'h0);
    chk("t5_busy", busy[3], 32'h0);
    idle(3);

`ifdef QM_RUN_GATE_EN
    // 6: run gate gives an aligned start
    run_v = 1'b0;
    for (int c = 0; c < NCH; c++) step(1'b1, 2'(c), 2'b01, 7'(c + 40), '0);
    idle(2);
    run_v = 1'b1;
    idle(1);
    chk("t6_fire", {trg[31], trg[23], trg[15], trg[7]}, 32'hf);
`endif

    // Random traffic
    for (int i = 0; i < 800; i++) begin
      logic [1:0] op;
      logic [IW-1:0] a;
      logic [NCH-1:0] fl;
      op = 2'($urandom_range(0, 3));
      a  = (op == 2'b00) ? 7'($urandom_range(0, 6)) : 7'($urandom);
      fl = ($urandom_range(0, 24) == 0) ? 4'(1 << $urandom_range(0, 3)) : 4'b0;
`ifdef QM_RUN_GATE_EN
      run_v = ($urandom_range(0, 3) != 0);
`endif
      step($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), op, a, fl);
    end

    // Reset mid-operation takes effect asynchronously
    step(1'b1, 2'd1, 2'b00, 7'd6, '0);
    rst = 1'b1;
    #1;
    chk("arst_trg", trg, 32'h0);
    chk("arst_busy", busy, 32'h0);
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    run_v = 1'b1;
    step(1'b1, 2'd1, 2'b01, 7'h5a, '0);
    idle(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
